// File: rtl/spi_slave_pkg.sv
// Shared definitions for the SPI mode-0 slave: FSM encodings and default word width.
// The encodings match those used by the SPI master on the same bus.
package spi_slave_pkg;

  localparam int SPI_DATA_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2
  } spi_state_e;

  // Word handed to the TX shifter on a load: the buffered word, or zeros when empty.
  function automatic logic [SPI_DATA_W-1:0] pick_load_word(input logic full,
                                                           input logic [SPI_DATA_W-1:0] word);
    pick_load_word = full ? word : {SPI_DATA_W{1'b0}};
  endfunction

endpackage

// File: rtl/spi_slave_if.sv
// Pin-side and stream-side signals of the SPI slave, with modports for the slave
// (design) and master (surrounding logic / bench) views.
interface spi_slave_if #(
  parameter int DATA_W = 8
);
  logic              sclk;
  logic              cs_n;
  logic              mosi;
  logic              miso;
  logic              miso_oe;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              rx_overrun;
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic              tx_underrun;
  logic              busy;

  modport slave (
    input  sclk, cs_n, mosi, rx_ready, tx_data, tx_valid,
    output miso, miso_oe, rx_data, rx_valid, rx_overrun, tx_ready, tx_underrun, busy
  );

  modport master (
    output sclk, cs_n, mosi, rx_ready, tx_data, tx_valid,
    input  miso, miso_oe, rx_data, rx_valid, rx_overrun, tx_ready, tx_underrun, busy
  );
endinterface

// File: rtl/spi_slave_pin_sync.sv
// Synchronises the asynchronous SPI pins into the clk domain and detects sclk edges.
// cs_n resets to the deselected level so a reset never looks like a select.
module spi_slave_pin_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic sclk_i,
  input  logic cs_n_i,
  input  logic mosi_i,
  output logic cs_s_o,
  output logic mosi_s_o,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sclk_q;
  logic [SYNC_STAGES-1:0] cs_q;
  logic [SYNC_STAGES-1:0] mosi_q;
  logic                   sclk_dly_q;
  logic                   sclk_s;

  always_ff @(posedge clk) begin
    if (!rst) begin
      sclk_q     <= {SYNC_STAGES{1'b0}};
      cs_q       <= {SYNC_STAGES{1'b1}};
      mosi_q     <= {SYNC_STAGES{1'b0}};
      sclk_dly_q <= 1'b0;
    end else begin
      sclk_q     <= {sclk_q[SYNC_STAGES-2:0], sclk_i};
      cs_q       <= {cs_q[SYNC_STAGES-2:0], cs_n_i};
      mosi_q     <= {mosi_q[SYNC_STAGES-2:0], mosi_i};
      sclk_dly_q <= sclk_s;
    end
  end

  assign sclk_s   = sclk_q[SYNC_STAGES-1];
  assign cs_s_o   = cs_q[SYNC_STAGES-1];
  assign mosi_s_o = mosi_q[SYNC_STAGES-1];
  assign rise_o   = sclk_s & ~sclk_dly_q;
  assign fall_o   = ~sclk_s & sclk_dly_q;

endmodule

// File: rtl/spi_slave.sv
// SPI mode-0 slave, MSB first: deserialises mosi into a valid/ready RX stream and
// serialises a one-entry TX buffer onto miso, all in the system clock domain.
module spi_slave
  import spi_slave_pkg::*;
#(
  parameter int DATA_W      = SPI_DATA_W,
  parameter int SYNC_STAGES = 2
) (
  input logic      clk,
  input logic      rst,
  spi_slave_if.slave bus
);

  localparam int                CNT_W    = (DATA_W > 2) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  logic cs_s, mosi_s, rise_s, fall_s;

  spi_slave_pin_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_pin_sync (
    .clk      (clk),
    .rst      (rst),
    .sclk_i   (bus.sclk),
    .cs_n_i   (bus.cs_n),
    .mosi_i   (bus.mosi),
    .cs_s_o   (cs_s),
    .mosi_s_o (mosi_s),
    .rise_o   (rise_s),
    .fall_o   (fall_s)
  );

  spi_state_e        state_q;
  logic [CNT_W-1:0]  bit_cnt_q;
  logic [DATA_W-1:0] rx_shift_q;
  logic [DATA_W-1:0] tx_shift_q;
  logic [DATA_W-1:0] rx_data_q;
  logic              rx_valid_q;
  logic              rx_overrun_q;
  logic [DATA_W-1:0] buf_q;
  logic              buf_full_q;
  logic              buf_full_d;
  logic              tx_underrun_q;
  logic              miso_q;
  logic              miso_oe_q;
  logic              busy_q;

  logic              reload_s;
  logic              rx_done_s;
  logic              tx_wr_s;
  logic [DATA_W-1:0] load_word_s;

  // A reload happens on entry to a word: the LOAD state or a falling edge at a word boundary.
  always_comb begin
    load_word_s = pick_load_word(buf_full_q, buf_q);
    tx_wr_s     = bus.tx_valid & ~buf_full_q;
    if (state_q == ST_LOAD) begin
      reload_s = 1'b1;
    end else if (state_q == ST_SHIFT) begin
      reload_s = ~cs_s & fall_s & (bit_cnt_q == {CNT_W{1'b0}});
    end else begin
      reload_s = 1'b0;
    end
    if (state_q == ST_SHIFT) begin
      rx_done_s = ~cs_s & rise_s & (bit_cnt_q == LAST_BIT);
    end else begin
      rx_done_s = 1'b0;
    end
    // A write needs an empty buffer and a reload of a full one empties it, so they never collide.
    buf_full_d = tx_wr_s | (buf_full_q & ~reload_s);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      bit_cnt_q  <= {CNT_W{1'b0}};
      rx_shift_q <= {DATA_W{1'b0}};
      tx_shift_q <= {DATA_W{1'b0}};
      miso_q     <= 1'b0;
      miso_oe_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          miso_q    <= 1'b0;
          miso_oe_q <= 1'b0;
          bit_cnt_q <= {CNT_W{1'b0}};
          if (!cs_s) begin
            state_q <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          tx_shift_q <= load_word_s;
          miso_q     <= load_word_s[DATA_W-1];
          miso_oe_q  <= 1'b1;
          bit_cnt_q  <= {CNT_W{1'b0}};
          state_q    <= ST_SHIFT;
        end
        ST_SHIFT: begin
          if (cs_s) begin
            // Deselect wins over any edge seen in the same cycle; the partial word is dropped.
            state_q   <= ST_IDLE;
            bit_cnt_q <= {CNT_W{1'b0}};
            miso_q    <= 1'b0;
            miso_oe_q <= 1'b0;
          end else if (rise_s) begin
            rx_shift_q <= {rx_shift_q[DATA_W-2:0], mosi_s};
            bit_cnt_q  <= (bit_cnt_q == LAST_BIT) ? {CNT_W{1'b0}} : bit_cnt_q + CNT_W'(1);
          end else if (fall_s) begin
            if (bit_cnt_q == {CNT_W{1'b0}}) begin
              tx_shift_q <= load_word_s;
              miso_q     <= load_word_s[DATA_W-1];
            end else begin
              tx_shift_q <= {tx_shift_q[DATA_W-2:0], 1'b0};
              miso_q     <= tx_shift_q[DATA_W-2];
            end
          end
        end
        default: begin
          state_q   <= ST_IDLE;
          miso_q    <= 1'b0;
          miso_oe_q <= 1'b0;
        end
      endcase
    end
  end

  // RX holding register: a completing word always wins over a same-cycle accept.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rx_data_q    <= {DATA_W{1'b0}};
      rx_valid_q   <= 1'b0;
      rx_overrun_q <= 1'b0;
    end else begin
      rx_overrun_q <= 1'b0;
      if (rx_done_s) begin
        rx_data_q    <= {rx_shift_q[DATA_W-2:0], mosi_s};
        rx_valid_q   <= 1'b1;
        rx_overrun_q <= rx_valid_q & ~bus.rx_ready;
      end else if (rx_valid_q && bus.rx_ready) begin
        rx_valid_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      buf_q         <= {DATA_W{1'b0}};
      buf_full_q    <= 1'b0;
      tx_underrun_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      if (tx_wr_s) begin
        buf_q <= bus.tx_data;
      end
      buf_full_q    <= buf_full_d;
      tx_underrun_q <= reload_s & ~buf_full_q;
      busy_q        <= ~cs_s;
    end
  end

  assign bus.miso        = miso_q;
  assign bus.miso_oe     = miso_oe_q;
  assign bus.rx_data     = rx_data_q;
  assign bus.rx_valid    = rx_valid_q;
  assign bus.rx_overrun  = rx_overrun_q;
  assign bus.tx_ready    = ~buf_full_q;
  assign bus.tx_underrun = tx_underrun_q;
  assign bus.busy        = busy_q;

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: a bus-functional SPI master at clk/8, a TX feeder
// and pulse monitors, with a table of single-word transfers plus burst/abort/reset sequences.
module tb_spi_slave;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  spi_slave_if #(.DATA_W(8)) bus ();

  spi_slave #(
    .DATA_W      (8),
    .SYNC_STAGES (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  int unsigned ovr_cnt = 0;
  int unsigned unr_cnt = 0;
  logic [7:0]  rx_log[$];
  logic [7:0]  tx_q[$];

  typedef struct {
    logic [7:0] tx_word;
    logic [7:0] mosi_word;
    logic [7:0] exp_rx_data;
    logic [7:0] exp_master_rx;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_tx_full();
    int n = 0;
    while (bus.tx_ready && n < 40) begin
      wait_clk(1);
      n++;
    end
    check("tx_buffer_fill", {31'd0, bus.tx_ready}, 32'd0);
  endtask

  task automatic cs_begin();
    bus.cs_n = 1'b0;
    wait_clk(2);
  endtask

  // One word on the wire; the last falling edge can coincide with cs_n rising.
  task automatic spi_word(input logic [7:0] w, input int nbits, input bit end_cs,
                          output logic [7:0] got);
    got = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      bus.mosi = w[7-i];
      wait_clk(4);
      got[7-i] = bus.miso;
      bus.sclk = 1'b1;
      wait_clk(4);
      bus.sclk = 1'b0;
      if (end_cs && i == nbits - 1) bus.cs_n = 1'b1;
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (bus.rx_overrun)  ovr_cnt++;
      if (bus.tx_underrun) unr_cnt++;
      if (bus.rx_valid && bus.rx_ready) rx_log.push_back(bus.rx_data);
    end
  end

  initial begin
    bus.tx_valid = 1'b0;
    bus.tx_data  = 8'h00;
    forever begin
      @(negedge clk);
      if (tx_q.size() > 0 && bus.tx_ready && rst) begin
        bus.tx_data  = tx_q[0];
        bus.tx_valid = 1'b1;
        @(posedge clk);
        void'(tx_q.pop_front());
        #1;
        bus.tx_valid = 1'b0;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vec_t        vecs[5];
    logic [7:0]  got, got2;
    logic [7:0]  burst_mosi[4];
    logic [7:0]  burst_tx[4];
    logic [7:0]  burst_got[4];
    logic [7:0]  e;
    int unsigned u0, o0;
    int          idx0;

    vecs[0] = '{8'hA5, 8'h3C, 8'h3C, 8'hA5};
    vecs[1] = '{8'h00, 8'hFF, 8'hFF, 8'h00};
    vecs[2] = '{8'hFF, 8'h00, 8'h00, 8'hFF};
    vecs[3] = '{8'h5A, 8'hC3, 8'hC3, 8'h5A};
    vecs[4] = '{8'h81, 8'h7E, 8'h7E, 8'h81};
    burst_mosi = '{8'h11, 8'h22, 8'h33, 8'h44};
    burst_tx   = '{8'hC1, 8'hC2, 8'hC3, 8'hC4};

    rst          = 1'b0;
    bus.sclk     = 1'b0;
    bus.cs_n     = 1'b1;
    bus.mosi     = 1'b0;
    bus.rx_ready = 1'b0;
    wait_clk(3);
    check("rst_miso",        {31'd0, bus.miso},        32'd0);
    check("rst_miso_oe",     {31'd0, bus.miso_oe},     32'd0);
    check("rst_rx_data",     {24'd0, bus.rx_data},     32'd0);
    check("rst_rx_valid",    {31'd0, bus.rx_valid},    32'd0);
    check("rst_rx_overrun",  {31'd0, bus.rx_overrun},  32'd0);
    check("rst_tx_ready",    {31'd0, bus.tx_ready},    32'd1);
    check("rst_tx_underrun", {31'd0, bus.tx_underrun}, 32'd0);
    check("rst_busy",        {31'd0, bus.busy},        32'd0);
    rst = 1'b1;
    wait_clk(4);

    // Single-word transfers with a preloaded TX word.
    for (int v = 0; v < 5; v++) begin
      tx_q.push_back(vecs[v].tx_word);
      wait_tx_full();
      u0 = unr_cnt;
      o0 = ovr_cnt;
      cs_begin();
      spi_word(vecs[v].mosi_word, 8, 1'b1, got);
      wait_clk(4);
      check("vec_rx_valid",  {31'd0, bus.rx_valid}, 32'd1);
      check("vec_rx_data",   {24'd0, bus.rx_data},  {24'd0, vecs[v].exp_rx_data});
      check("vec_master_rx", {24'd0, got},          {24'd0, vecs[v].exp_master_rx});
      check("vec_underrun",  unr_cnt - u0,          32'd0);
      check("vec_overrun",   ovr_cnt - o0,          32'd0);
      check("vec_tx_ready",  {31'd0, bus.tx_ready}, 32'd1);
      check("vec_busy_idle", {31'd0, bus.busy},     32'd0);
      check("vec_oe_idle",   {31'd0, bus.miso_oe},  32'd0);
      bus.rx_ready = 1'b1;
      wait_clk(1);
      bus.rx_ready = 1'b0;
      wait_clk(1);
      check("vec_rx_accept", {31'd0, bus.rx_valid}, 32'd0);
    end

    // Back-to-back words with an empty TX buffer and no consumer.
    u0 = unr_cnt;
    o0 = ovr_cnt;
    cs_begin();
    spi_word(8'h01, 8, 1'b0, got);
    spi_word(8'h80, 8, 1'b1, got2);
    wait_clk(4);
    check("b2b_rx_data",  {24'd0, bus.rx_data},  32'h80);
    check("b2b_rx_valid", {31'd0, bus.rx_valid}, 32'd1);
    check("b2b_overrun",  ovr_cnt - o0,          32'd1);
    check("b2b_underrun", unr_cnt - u0,          32'd2);
    check("b2b_miso_w0",  {24'd0, got},          32'h00);
    check("b2b_miso_w1",  {24'd0, got2},         32'h00);
    bus.rx_ready = 1'b1;
    wait_clk(1);
    bus.rx_ready = 1'b0;
    wait_clk(1);

    // Deselect after 5 bits, then a clean word.
    cs_begin();
    spi_word(8'hFF, 5, 1'b1, got);
    wait_clk(6);
    check("abort_no_valid", {31'd0, bus.rx_valid}, 32'd0);
    cs_begin();
    spi_word(8'h55, 8, 1'b1, got);
    wait_clk(4);
    check("abort_next_valid", {31'd0, bus.rx_valid}, 32'd1);
    check("abort_next_data",  {24'd0, bus.rx_data},  32'h55);
    check("abort_next_miso",  {24'd0, got},          32'h00);

    // Four-word burst with the consumer always ready and TX refilled each word.
    bus.rx_ready = 1'b1;
    wait_clk(2);
    foreach (burst_tx[k]) tx_q.push_back(burst_tx[k]);
    wait_tx_full();
    u0   = unr_cnt;
    o0   = ovr_cnt;
    idx0 = rx_log.size();
    cs_begin();
    for (int k = 0; k < 4; k++) spi_word(burst_mosi[k], 8, (k == 3), burst_got[k]);
    wait_clk(4);
    check("burst_rx_count", rx_log.size() - idx0, 32'd4);
    for (int k = 0; k < 4; k++) begin
      e = (rx_log.size() > idx0 + k) ? rx_log[idx0 + k] : 8'h00;
      check("burst_rx_word",   {24'd0, e},            {24'd0, burst_mosi[k]});
      check("burst_miso_word", {24'd0, burst_got[k]}, {24'd0, burst_tx[k]});
    end
    check("burst_underrun", unr_cnt - u0,          32'd0);
    check("burst_overrun",  ovr_cnt - o0,          32'd0);
    check("burst_rx_valid", {31'd0, bus.rx_valid}, 32'd0);
    bus.rx_ready = 1'b0;

    // Reset in the middle of a word, then a normal transfer.
    cs_begin();
    spi_word(8'hF0, 3, 1'b0, got);
    check("mid_busy",    {31'd0, bus.busy},    32'd1);
    check("mid_miso_oe", {31'd0, bus.miso_oe}, 32'd1);
    rst = 1'b0;
    wait_clk(1);
    check("mrst_miso",     {31'd0, bus.miso},     32'd0);
    check("mrst_miso_oe",  {31'd0, bus.miso_oe},  32'd0);
    check("mrst_rx_data",  {24'd0, bus.rx_data},  32'd0);
    check("mrst_rx_valid", {31'd0, bus.rx_valid}, 32'd0);
    check("mrst_tx_ready", {31'd0, bus.tx_ready}, 32'd1);
    check("mrst_busy",     {31'd0, bus.busy},     32'd0);
    rst      = 1'b1;
    bus.cs_n = 1'b1;
    wait_clk(6);
    cs_begin();
    spi_word(8'h9A, 8, 1'b1, got);
    wait_clk(4);
    check("post_rst_valid", {31'd0, bus.rx_valid}, 32'd1);
    check("post_rst_data",  {24'd0, bus.rx_data},  32'h9A);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
